// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch stage. Drives the instruction memory byte address from
//               the PC register, captures the returned word into the IF/ID
//               register, honours decode back-pressure and execute redirects,
//               and stops fetching once the PC runs past the program end.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] LAST_ADDR = 32'd84
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        if_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        done,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] c_pc_step    = 32'd4;
  localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instruction;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_plus4;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target_aligned;
  logic        w_advance;
  logic        w_deliver;

  // Next sequential PC (wraps modulo 2^32) and the word-aligned redirect
  // target; masking keeps every target bit in use while dropping the low two.
  assign w_pc_plus4       = r_pc + c_pc_step;
  assign w_target_aligned = redirect_target & c_align_mask;

  // Fetch when running and the IF/ID slot is empty or being drained;
  // a redirect in the same cycle kills the fetch of the wrong-path word.
  assign w_advance = (r_state == ST_FETCH) && (!r_if_valid || if_ready) && !redirect;
  assign w_deliver = r_if_valid && if_ready && !redirect;

  // PC, IF/ID register, delivered-instruction counter and FETCH/DONE state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_FETCH;
      r_pc             <= RESET_PC;
      r_if_valid       <= 1'b0;
      r_if_instruction <= 32'd0;
      r_if_pc          <= 32'd0;
      r_if_pc_plus4    <= 32'd0;
      r_fetch_count    <= 32'd0;
    end else if (redirect) begin
      // Redirect outranks stall, advance and DONE; the held word is dropped
      // without being counted.
      r_pc       <= w_target_aligned;
      r_if_valid <= 1'b0;
      r_state    <= (w_target_aligned <= LAST_ADDR) ? ST_FETCH : ST_DONE;
    end else begin
      if (w_deliver) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_advance) begin
        r_if_instruction <= imem_instruction;
        r_if_pc          <= r_pc;
        r_if_pc_plus4    <= w_pc_plus4;
        r_if_valid       <= 1'b1;
        r_pc             <= w_pc_plus4;
        // Capturing the last word ends the program; a wrap to 0 (only
        // possible when LAST_ADDR is the top word) keeps fetching.
        if (w_pc_plus4 > LAST_ADDR) begin
          r_state <= ST_DONE;
        end
      end else if (w_deliver) begin
        // Slot drained with nothing behind it (DONE state).
        r_if_valid <= 1'b0;
      end
    end
  end

  assign imem_address   = r_pc;
  assign if_valid       = r_if_valid;
  assign if_instruction = r_if_instruction;
  assign if_pc          = r_if_pc;
  assign if_pc_plus4    = r_if_pc_plus4;
  assign done           = (r_state == ST_DONE);
  assign fetch_count    = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch: directed scenarios
//               plus a randomized run scored against a program-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] LAST = 32'd84;

  logic        clock;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        if_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        done;
  logic [31:0] fetch_count;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:63];

  instruction_fetch #(.RESET_PC(32'd0), .LAST_ADDR(LAST)) dut (
    .clock            (clock),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .if_ready         (if_ready),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .if_valid         (if_valid),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .if_pc_plus4      (if_pc_plus4),
    .done             (done),
    .fetch_count      (fetch_count)
  );

  // Combinational instruction memory.
  assign imem_instruction = mem[imem_address[7:2]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; if_ready = 1'b1; redirect = 1'b0; redirect_target = 32'd0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; if_ready = 1'b1; redirect = 1'b0; redirect_target = 32'd0;
    tick();
    tests++;
    if (imem_address !== 32'd0 || if_valid !== 1'b0 || if_instruction !== 32'd0 ||
        if_pc !== 32'd0 || if_pc_plus4 !== 32'd0 || done !== 1'b0 || fetch_count !== 32'd0) begin
      fails++;
      $display("FAIL reset_state: addr=%h valid=%b instr=%h pc=%h pc4=%h done=%b cnt=%0d required all zero",
               imem_address, if_valid, if_instruction, if_pc, if_pc_plus4, done, fetch_count);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (if_instruction !== 32'h02324020 || if_pc !== 32'd0 || if_pc_plus4 !== 32'd4 || if_valid !== 1'b1) begin
      fails++;
      $display("FAIL first_fetch: instr=%h pc=%h pc4=%h valid=%b required 02324020/0/4/1",
               if_instruction, if_pc, if_pc_plus4, if_valid);
    end
    tick();
    tests++;
    if (if_instruction !== 32'h02744822 || if_pc !== 32'd4 || fetch_count !== 32'd1) begin
      fails++;
      $display("FAIL second_fetch: instr=%h pc=%h cnt=%0d required 02744822/4/1",
               if_instruction, if_pc, fetch_count);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] cnt;
    int n;
    apply_reset();
    n = 0;
    while (imem_address !== 32'd16 && n < 20) begin tick(); n++; end
    tests++;
    if (imem_address !== 32'd16) begin
      fails++;
      $display("FAIL redirect_reach16: addr=%h required 00000010", imem_address);
    end
    cnt = fetch_count;
    redirect = 1'b1; redirect_target = 32'd72;
    tick();
    redirect = 1'b0;
    tests++;
    if (imem_address !== 32'd72 || if_valid !== 1'b0 || fetch_count !== cnt) begin
      fails++;
      $display("FAIL redirect_bubble: addr=%h valid=%b cnt=%0d required 72/0/%0d",
               imem_address, if_valid, fetch_count, cnt);
    end
    tick();
    tests++;
    if (if_pc !== 32'd72 || if_valid !== 1'b1 || if_instruction !== mem[18] || fetch_count !== cnt) begin
      fails++;
      $display("FAIL redirect_target: pc=%h valid=%b instr=%h cnt=%0d required 72/1/%h/%0d",
               if_pc, if_valid, if_instruction, fetch_count, mem[18], cnt);
    end
  endtask

  task automatic test_stall();
    int n;
    apply_reset();
    n = 0;
    while (if_pc !== 32'd8 && n < 20) begin tick(); n++; end
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (if_pc !== 32'd8 || if_instruction !== mem[2] || imem_address !== 32'd12 ||
          fetch_count !== 32'd2 || if_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold[%0d]: pc=%h instr=%h addr=%h cnt=%0d valid=%b required 8/%h/12/2/1",
                 i, if_pc, if_instruction, imem_address, fetch_count, if_valid, mem[2]);
      end
    end
    if_ready = 1'b1;
    tick();
    tests++;
    if (if_pc !== 32'd12 || if_instruction !== mem[3] || fetch_count !== 32'd3) begin
      fails++;
      $display("FAIL stall_resume: pc=%h instr=%h cnt=%0d required 12/%h/3",
               if_pc, if_instruction, fetch_count, mem[3]);
    end
  endtask

  task automatic test_straight_line();
    int n;
    apply_reset();
    n = 0;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    tests++;
    if (done !== 1'b1 || if_pc !== 32'd84 || if_valid !== 1'b1 || fetch_count !== 32'd21) begin
      fails++;
      $display("FAIL done_edge: done=%b pc=%h valid=%b cnt=%0d required 1/84/1/21",
               done, if_pc, if_valid, fetch_count);
    end
    tick();
    tests++;
    if (if_valid !== 1'b0 || fetch_count !== 32'd22 || imem_address !== 32'd88 || done !== 1'b1) begin
      fails++;
      $display("FAIL done_drain: valid=%b cnt=%0d addr=%h done=%b required 0/22/88/1",
               if_valid, fetch_count, imem_address, done);
    end
    tick();
    tick();
    tests++;
    if (imem_address !== 32'd88 || fetch_count !== 32'd22 || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL done_frozen: addr=%h cnt=%0d valid=%b required 88/22/0",
               imem_address, fetch_count, if_valid);
    end
  endtask

  task automatic test_redirect_past_end();
    apply_reset();
    tick();
    tick();
    redirect = 1'b1; redirect_target = 32'd200;
    tick();
    tests++;
    if (done !== 1'b1 || if_valid !== 1'b0 || imem_address !== 32'd200) begin
      fails++;
      $display("FAIL redirect_past: done=%b valid=%b addr=%h required 1/0/200",
               done, if_valid, imem_address);
    end
    redirect_target = 32'd7;
    tick();
    redirect = 1'b0;
    tests++;
    if (imem_address !== 32'd4 || done !== 1'b0) begin
      fails++;
      $display("FAIL redirect_align: addr=%h done=%b required 4/0", imem_address, done);
    end
    tick();
    tests++;
    if (if_pc !== 32'd4 || if_valid !== 1'b1 || if_instruction !== mem[1]) begin
      fails++;
      $display("FAIL redirect_align_fetch: pc=%h valid=%b instr=%h required 4/1/%h",
               if_pc, if_valid, if_instruction, mem[1]);
    end
  endtask

  task automatic test_async_reset();
    int n;
    apply_reset();
    n = 0;
    while (fetch_count !== 32'd5 && n < 20) begin tick(); n++; end
    tests++;
    if (fetch_count !== 32'd5 || if_valid !== 1'b1) begin
      fails++;
      $display("FAIL async_setup: cnt=%0d valid=%b required 5/1", fetch_count, if_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (if_valid !== 1'b0 || fetch_count !== 32'd0 || imem_address !== 32'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: valid=%b cnt=%0d addr=%h done=%b required 0/0/0/0",
               if_valid, fetch_count, imem_address, done);
    end
    #2;
    reset = 1'b1;
    tick();
    tests++;
    if (if_pc !== 32'd0 || if_instruction !== mem[0] || if_valid !== 1'b1) begin
      fails++;
      $display("FAIL async_release: pc=%h instr=%h valid=%b required 0/%h/1",
               if_pc, if_instruction, if_valid, mem[0]);
    end
  endtask

  // Random back-pressure and redirects. The model only knows program order:
  // delivered words come from consecutive addresses starting at the last
  // redirect target (or 0), never past LAST, and each handshake counts once.
  task automatic test_random();
    logic [31:0] exp_next;
    logic [31:0] exp_cnt;
    logic [31:0] tgt;
    logic        rdy;
    logic        rd;
    apply_reset();
    exp_next = 32'd0;
    exp_cnt  = 32'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 9) == 0);
      tgt = $urandom_range(0, 120);
      if_ready = rdy; redirect = rd; redirect_target = tgt;
      if (rd) begin
        exp_next = {tgt[31:2], 2'b00};
      end else if (if_valid && rdy) begin
        tests++;
        if (exp_next > LAST || if_pc !== exp_next || if_pc_plus4 !== exp_next + 32'd4 ||
            if_instruction !== mem[exp_next[7:2]]) begin
          fails++;
          $display("FAIL rand_deliver[%0d]: pc=%h pc4=%h instr=%h required pc=%h (limit %h)",
                   cyc, if_pc, if_pc_plus4, if_instruction, exp_next, LAST);
        end
        exp_next = exp_next + 32'd4;
        exp_cnt  = exp_cnt + 32'd1;
      end
      tick();
      tests++;
      if (fetch_count !== exp_cnt) begin
        fails++;
        $display("FAIL rand_count[%0d]: cnt=%0d required %0d", cyc, fetch_count, exp_cnt);
      end
      if (rd) begin
        tests++;
        if (if_valid !== 1'b0 || imem_address !== exp_next || done !== (exp_next > LAST)) begin
          fails++;
          $display("FAIL rand_redirect[%0d]: valid=%b addr=%h done=%b required 0/%h/%b",
                   cyc, if_valid, imem_address, done, exp_next, exp_next > LAST);
        end
      end
    end
    redirect = 1'b0;
    if_ready = 1'b1;
  endtask

  initial begin
    mem[0] = 32'h02324020;
    mem[1] = 32'h02744822;
    for (int i = 2; i < 64; i++) mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
    reset = 1'b0; if_ready = 1'b1; redirect = 1'b0; redirect_target = 32'd0;

    test_reset();
    test_redirect();
    test_stall();
    test_straight_line();
    test_redirect_past_end();
    test_async_reset();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

- Fetch stage that drives the instruction memory's byte address and captures the returned word into an IF/ID register for the decoder.
- Holds the program counter and advances it by 4 per delivered instruction.
- Accepts a taken-branch redirect from execute and squashes the wrong-path word.
- Stops issuing at the end of the loaded program; sits between the instruction memory and the decode stage.

## Interface

Parameters:
- RESET_PC, 32'd0 — PC value after reset.
- LAST_ADDR, 32'd84 — byte address of the last valid instruction word; any PC above it is past end of program.

Ports:
- clock  input  1  — single clock; all state updates on its rising edge.
- reset  input  1  — asynchronous, active-low; asserting it (0) forces reset state immediately, independent of clock.
- imem_address  output  32  — byte address to instruction memory; equals PC register directly (no combinational path from inputs).
- imem_instruction  input  32  — word read from instruction memory, valid combinationally in the same cycle as imem_address.
- if_ready  input  1  — decode accepts the current IF/ID contents this cycle.
- redirect  input  1  — taken branch/jump from execute.
- redirect_target  input  32  — new PC when redirect=1.
- if_valid  output  1  — IF/ID register holds a live instruction.
- if_instruction  output  32  — captured instruction.
- if_pc  output  32  — byte address the captured instruction came from.
- if_pc_plus4  output  32  — if_pc + 4; decode uses it for branch target arithmetic.
- done  output  1  — PC has passed LAST_ADDR; no further fetches.
- fetch_count  output  32  — number of instructions delivered to decode (handshakes completed).

## Operation

- States: FETCH, DONE. Reset enters FETCH.
- Reset values:
  - PC = RESET_PC, so imem_address = RESET_PC.
  - if_valid = 0, if_instruction = 0, if_pc = 0, if_pc_plus4 = 0.
  - done = 0, fetch_count = 0.
- advance = (state==FETCH) && (!if_valid || if_ready) && !redirect.
- On advance:
  - if_instruction <= imem_instruction, if_pc <= PC, if_pc_plus4 <= PC+4, if_valid <= 1.
  - PC <= PC+4.
  - If PC+4 > LAST_ADDR, state <= DONE.
- Holding (if_valid && !if_ready && !redirect): PC and every IF/ID field hold their values unchanged.
- Delivered (if_valid && if_ready && !redirect): fetch_count <= fetch_count + 1.
  - If not advancing in the same cycle (state DONE), if_valid <= 0.
- Redirect (priority over stall, advance and DONE):
  - PC <= {redirect_target[31:2], 2'b00}; the low two bits are ignored.
  - if_valid <= 0; the wrong-path word is squashed and not counted.
  - state <= FETCH if the aligned target <= LAST_ADDR, else DONE.
- DONE: no fetches; PC frozen. A pending valid word may still be delivered. done = (state==DONE).
- Arithmetic: 32-bit unsigned.
  - PC+4 wraps modulo 2^32. Wrap cannot occur unless LAST_ADDR >= 32'hFFFFFFFC; in that case fetch continues from 0.
  - The LAST_ADDR comparison is unsigned.
  - fetch_count wraps modulo 2^32.
- The branch target is computed upstream: target = pc_plus4 + (sign_extend(imm16) << 2). This block does no immediate math.

## Timing

- Fetch latency: instruction at address A appears on if_instruction/if_valid one clock after imem_address = A, provided advance=1 in that cycle.
- Throughput: one instruction per clock while if_ready=1.
- Redirect penalty:
  - Edge k (redirect sampled): PC = target, if_valid = 0.
  - Edge k+1: target instruction is valid in IF/ID.
  - Exactly one bubble cycle.
- Redirect while if_ready=0: redirect wins; the held word is dropped.
- Reset asserted mid-operation:
  - All outputs take their reset values asynchronously, within the same cycle.
  - On release, the first fetch of RESET_PC occurs at the next rising edge.
- done rises on the edge that captures address LAST_ADDR.

## Test plan

- Reset, memory loaded with the standard 22-word program, if_ready=1 → imem_address=0 during reset; after one edge if_instruction=32'h02324020, if_pc=0; next edge if_instruction=32'h02744822, if_pc=4.
- Redirect=1 with target=72 while PC=16 → next edge imem_address=72, if_valid=0; following edge if_pc=72, if_valid=1, fetch_count not incremented for the squashed word.
- if_ready=0 for 3 cycles with if_pc=8 → if_instruction, if_pc and imem_address (12) stable for 3 cycles; fetch_count unchanged; delivery resumes on the cycle after if_ready returns to 1.
- Run straight-line from 0 with LAST_ADDR=84, if_ready=1 → done=1 on the edge capturing if_pc=84; if_valid drops the cycle after; fetch_count=22; imem_address frozen at 88.
- Redirect target=200 (> LAST_ADDR) → state DONE, done=1, if_valid=0 next edge. Redirect target=7 → PC=4.
- Reset pulled low asynchronously mid-cycle with if_valid=1, fetch_count=5 → immediately if_valid=0, fetch_count=0, imem_address=RESET_PC; first capture after release is word 0.
